// File: rtl/gate_trainer_checker.sv
// Self-test sequencer for the two-input gate bank: walks a/b through 00,01,10,11,
// checks the seven gate outputs and reports a fail mask plus pass flag.
// Optional mismatch counter output err_count is enabled by GATE_CHECKER_ERRCNT_EN.
//
// state     | meaning
// ST_IDLE   | waiting for start; results held
// ST_DRIVE  | stimulus applied, settle counter running
// ST_SAMPLE | gate outputs compared, mismatches merged
// ST_REPORT | done pulse, pass/fail_mask final
module gate_trainer_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       not_a_in,
  input  logic       nand_in,
  input  logic       nor_in,
  input  logic       xor_in,
  input  logic       xnor_in,
  output logic       drive_a,
  output logic       drive_b,
  output logic [1:0] vector_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask
`ifdef GATE_CHECKER_ERRCNT_EN
  ,
  output logic [4:0] err_count
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_SAMPLE, ST_REPORT} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       a, b;
  logic [6:0] observed, expected, mismatch;

  assign a        = vector_idx[1];
  assign b        = vector_idx[0];
  assign drive_a  = vector_idx[1];
  assign drive_b  = vector_idx[0];
  assign observed = {xnor_in, xor_in, nor_in, nand_in, not_a_in, or_in, and_in};
  assign expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  assign mismatch = observed ^ expected;

`ifdef GATE_CHECKER_ERRCNT_EN
  logic [2:0] mis_pop;
  always_comb begin
    mis_pop = '0;
    for (int i = 0; i < 7; i++) mis_pop = mis_pop + 3'(mismatch[i]);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_DRIVE;
      ST_DRIVE:  if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = (vector_idx == 2'd3) ? ST_REPORT : ST_DRIVE;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_REPORT);
  end

  // Vector index, settle counter and results; pass folds in the last vector's bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      vector_idx <= '0;
      cnt_q      <= '0;
      fail_mask  <= '0;
      pass       <= 1'b0;
`ifdef GATE_CHECKER_ERRCNT_EN
      err_count  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            vector_idx <= '0;
            cnt_q      <= '0;
            fail_mask  <= '0;
            pass       <= 1'b0;
`ifdef GATE_CHECKER_ERRCNT_EN
            err_count  <= '0;
`endif
          end
        end
        ST_DRIVE: cnt_q <= cnt_q + 4'd1;
        ST_SAMPLE: begin
          fail_mask <= fail_mask | mismatch;
`ifdef GATE_CHECKER_ERRCNT_EN
          err_count <= err_count + {2'b00, mis_pop};
`endif
          if (vector_idx == 2'd3) begin
            pass <= ~|(fail_mask | mismatch);
          end else begin
            vector_idx <= vector_idx + 2'd1;
            cnt_q      <= '0;
          end
        end
        ST_REPORT: vector_idx <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_trainer_checker.sv
// Scoreboard bench for gate_trainer_checker: two instances (settle 2 and 1) fed by
// a gate-bank model with selectable faults.
module tb_gate_trainer_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  int   fault = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] mask;
    logic       pass;
    logic [4:0] errs;
  } exp_t;
  exp_t sb[$];

  logic       d0_a, d0_b, d0_busy, d0_done, d0_pass;
  logic [1:0] d0_vec;
  logic [6:0] d0_mask, g0;
  logic       d1_a, d1_b, d1_busy, d1_done, d1_pass;
  logic [1:0] d1_vec;
  logic [6:0] d1_mask, g1;
  logic       start0, start1;

  function automatic logic [6:0] gates(input int f, input logic a, input logic b);
    logic [6:0] g;
    g = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    if (f == 1) g[0] = 1'b0;
    if (f == 2) g[6] = a ^ b;
    if (f == 3) g[2] = a;
    return g;
  endfunction

  assign g0 = gates(fault, d0_a, d0_b);
  assign g1 = gates(fault, d1_a, d1_b);
  assign start0 = start & ~sel;
  assign start1 = start & sel;

`ifdef GATE_CHECKER_ERRCNT_EN
  logic [4:0] d0_err, d1_err;
`endif

  gate_trainer_checker #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .and_in(g0[0]), .or_in(g0[1]), .not_a_in(g0[2]), .nand_in(g0[3]),
    .nor_in(g0[4]), .xor_in(g0[5]), .xnor_in(g0[6]),
    .drive_a(d0_a), .drive_b(d0_b), .vector_idx(d0_vec), .busy(d0_busy),
    .done(d0_done), .pass(d0_pass), .fail_mask(d0_mask)
`ifdef GATE_CHECKER_ERRCNT_EN
    , .err_count(d0_err)
`endif
  );

  gate_trainer_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .and_in(g1[0]), .or_in(g1[1]), .not_a_in(g1[2]), .nand_in(g1[3]),
    .nor_in(g1[4]), .xor_in(g1[5]), .xnor_in(g1[6]),
    .drive_a(d1_a), .drive_b(d1_b), .vector_idx(d1_vec), .busy(d1_busy),
    .done(d1_done), .pass(d1_pass), .fail_mask(d1_mask)
`ifdef GATE_CHECKER_ERRCNT_EN
    , .err_count(d1_err)
`endif
  );

  logic       o_a, o_b, o_busy, o_done, o_pass;
  logic [1:0] o_vec;
  logic [6:0] o_mask;
  assign o_a    = sel ? d1_a    : d0_a;
  assign o_b    = sel ? d1_b    : d0_b;
  assign o_busy = sel ? d1_busy : d0_busy;
  assign o_done = sel ? d1_done : d0_done;
  assign o_pass = sel ? d1_pass : d0_pass;
  assign o_vec  = sel ? d1_vec  : d0_vec;
  assign o_mask = sel ? d1_mask : d0_mask;
`ifdef GATE_CHECKER_ERRCNT_EN
  logic [4:0] o_err;
  assign o_err = sel ? d1_err : d0_err;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; asserts start immediately so it is sampled at the next edge.
  task automatic run(input int flt, input logic use1, input logic [6:0] emask,
                     input logic epass, input logic [4:0] eerr, input int x1, input int x2);
    int settle, done_cyc, ev;
    exp_t e;
    sel = use1;
    fault = flt;
    settle = use1 ? 1 : 2;
    done_cyc = 4 * (settle + 1) + 1;
    e.mask = emask; e.pass = epass; e.errs = eerr;
    sb.push_back(e);
    start = 1'b1;
    step();
    for (int c = 1; c <= done_cyc; c++) begin
      start = (c == x1) || (c == x2);
      ev = (c == done_cyc) ? 3 : (c - 1) / (settle + 1);
      chk("vector_idx", 32'(o_vec), 32'(ev));
      chk("drive_ab", 32'({o_a, o_b}), 32'(ev));
      chk("busy", 32'(o_busy), 32'd1);
      chk("done", 32'(o_done), 32'(c == done_cyc));
      if (c == 1) begin
        chk("mask_cleared", 32'(o_mask), 32'd0);
        chk("pass_cleared", 32'(o_pass), 32'd0);
      end
      if (o_done && sb.size() > 0) begin
        e = sb.pop_front();
        chk("fail_mask", 32'(o_mask), 32'(e.mask));
        chk("pass", 32'(o_pass), 32'(e.pass));
`ifdef GATE_CHECKER_ERRCNT_EN
        chk("err_count", 32'(o_err), 32'(e.errs));
`endif
      end
      step();
    end
    start = 1'b0;
    chk("done_seen", 32'(sb.size()), 32'd0);
    sb.delete();
    chk("busy_after", 32'(o_busy), 32'd0);
    chk("done_after", 32'(o_done), 32'd0);
    chk("drive_after", 32'({o_a, o_b, o_vec}), 32'd0);
    chk("mask_hold", 32'(o_mask), 32'(emask));
    chk("pass_hold", 32'(o_pass), 32'(epass));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bit bad;
    exp_t e;
    repeat (3) step();
    chk("rst_dut0", 32'({d0_a, d0_b, d0_vec, d0_busy, d0_done, d0_pass, d0_mask}), 32'd0);
    chk("rst_dut1", 32'({d1_a, d1_b, d1_vec, d1_busy, d1_done, d1_pass, d1_mask}), 32'd0);
`ifdef GATE_CHECKER_ERRCNT_EN
    chk("rst_err", 32'({d0_err, d1_err}), 32'd0);
`endif
    rst = 1'b0;
    step();

    run(0, 1'b0, 7'h00, 1'b1, 5'd0, -1, -1);
    run(1, 1'b0, 7'h01, 1'b0, 5'd1, -1, -1);
    run(2, 1'b0, 7'h40, 1'b0, 5'd4, 5, 13);
    run(0, 1'b0, 7'h00, 1'b1, 5'd0, -1, -1);
    run(3, 1'b0, 7'h04, 1'b0, 5'd4, -1, -1);

    // reset during vector 2 DRIVE
    sel = 1'b0; fault = 1;
    e.mask = 7'h01; e.pass = 1'b0; e.errs = 5'd1;
    sb.push_back(e);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    chk("mid_vec", 32'(d0_vec), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out", 32'({d0_a, d0_b, d0_vec, d0_busy, d0_done, d0_pass, d0_mask}), 32'd0);
`ifdef GATE_CHECKER_ERRCNT_EN
    chk("mid_rst_err", 32'(d0_err), 32'd0);
`endif
    sb.delete();
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (d0_done || d0_busy) bad = 1'b1;
      step();
    end
    chk("no_done_after_rst", 32'(bad), 32'd0);

    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_beats_start", 32'(d0_busy), 32'd0);
    step();

    run(0, 1'b0, 7'h00, 1'b1, 5'd0, -1, -1);
    run(0, 1'b1, 7'h00, 1'b1, 5'd0, -1, -1);
    run(2, 1'b1, 7'h40, 1'b0, 5'd4, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_trainer_checker.md
# gate_trainer_checker

Sequential self-test driver for the digital trainer kit's two-input gate bank. It drives the shared `a`/`b` stimulus pair through all four input combinations and lets each settle. It then samples the seven gate outputs (AND, OR, NOT-a, NAND, NOR, XOR, XNOR) and compares them against the expected truth table. At the end of a run it reports a per-gate fail mask and a single pass flag for the on-board status LEDs.

## Interface
- `SETTLE_CYCLES`, default 2: DRIVE cycles per vector before sampling; legal range 1..15; held in a 4-bit counter.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `drive_a`  out  1  stimulus to gate input `a`.
- `drive_b`  out  1  stimulus to gate input `b`.
- `and_in`, `or_in`, `not_a_in`, `nand_in`, `nor_in`, `xor_in`, `xnor_in`  in  1 each  gate outputs under test.
- `vector_idx`  out  2  current vector; `drive_a` = `vector_idx[1]`, `drive_b` = `vector_idx[0]`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse in REPORT.
- `pass`  out  1  high when the last completed run had no mismatches.
- `fail_mask`  out  7  sticky per-gate mismatch flags. Bit 0 is AND, then 1 OR, 2 NOT-a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR.

## Operation
- States: IDLE, DRIVE, SAMPLE, REPORT.
- **IDLE:** when `start` is 1, go to DRIVE. On that same edge: `vector_idx` = 0, settle counter = 0, `fail_mask` = 0, `pass` = 0. Otherwise hold all outputs.
- **DRIVE:** counter increments each cycle. After `SETTLE_CYCLES` cycles in DRIVE, go to SAMPLE.
- **SAMPLE** (one cycle):
  - Compare the seven inputs against the expected values for the current `a`,`b`.
  - OR the mismatch bits into `fail_mask`.
  - If `vector_idx` < 3: increment `vector_idx`, clear the counter, go to DRIVE.
  - If `vector_idx` = 3: go to REPORT and leave `vector_idx` at 3.
- **REPORT** (one cycle): `done` = 1. Then go to IDLE, where `vector_idx` returns to 0.
- `pass` is registered on the SAMPLE→REPORT edge as NOR of the final `fail_mask`, including the vector-3 mismatch bits merged on that same edge.
- `pass` and `fail_mask` hold until the next accepted `start` or `rst`.
- `drive_a`/`drive_b` come directly from `vector_idx` and are glitch-free registered values. They read 0,0 in IDLE.
- `start` in DRIVE, SAMPLE or REPORT is ignored. No queuing.

## Timing
- All outputs reset to 0: `drive_a`, `drive_b`, `vector_idx`, `busy`, `done`, `pass`, `fail_mask`, and `err_count` when compiled in. State resets to IDLE.
- Start latency: `start` sampled at edge E0 means `busy` = 1 and DRIVE with vector 0 from the cycle after E0.
- Each vector takes `SETTLE_CYCLES`+1 cycles. `done` is high in cycle 4·(`SETTLE_CYCLES`+1)+1 after E0; that is cycle 13 for the default.
- `busy` is high from cycle 1 through the REPORT cycle, and low in the cycle after `done`.
- Earliest restart: `start` asserted in the cycle after REPORT.
- Inputs are compared in the SAMPLE cycle only. Values during DRIVE are don't-care.
- `rst` mid-run: on the next edge, all outputs read their reset values. No `done` pulse occurs and partial results are discarded.
- `rst` and `start` high together: reset wins.

## Configuration
- Macro: `GATE_CHECKER_ERRCNT_EN`.
- **Defined:** adds output `err_count` (out, 5 bits).
  - Cleared on an accepted `start`.
  - In each SAMPLE it adds the popcount of that vector's 7 mismatch bits.
  - Range is 0..28, so it cannot overflow.
  - Final value is valid from the REPORT cycle and held until the next `start` or `rst`.
- **Undefined:** the port and its adder are absent. All other behaviour is identical.

## Test plan
- **Correct gates:** `SETTLE_CYCLES`=2, single `start` pulse, all seven inputs driven by correct gate logic.
  - Required: `drive_a`,`drive_b` sequence 00,01,10,11, each held 3 cycles.
  - `done` pulse in cycle 13.
  - `pass`=1, `fail_mask`=0, `err_count`=0.
- **AND stuck-at-0:** required `fail_mask`=7'b0000001 (vector 11 only), `pass`=0, `err_count`=1.
- **XNOR wired to XOR:** required `fail_mask`=7'b1000000, `pass`=0, `err_count`=4.
- **`start` re-pulsed while busy:** `start` at cycles 5 and 13 (REPORT).
  - Required: exactly one `done`, with no run extension.
  - A new `start` at cycle 14 launches a second full run and clears the prior `fail_mask`.
- **Reset mid-run:** `rst` asserted during vector 2 DRIVE.
  - Required: all outputs at reset values next cycle; no `done` pulse.
  - The following `start` completes a normal run.
- **Minimum settle:** `SETTLE_CYCLES`=1, correct gates.
  - Required: each vector held 2 cycles, `done` in cycle 9, `pass`=1.
